// File: rtl/multiplier_top.sv
`default_nettype none
// ============================================================================
// multiplier_top : lane-parallel unsigned shift-add multiplier, valid/busy handshake
// Revision 1.0
// ============================================================================
module multiplier_top #(
  parameter int SIZE  = 6,
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     factor_a [SIZE],
  input  logic [WIDTH-1:0]     factor_b [SIZE/2],
  input  logic                 valid_in,
  output logic                 busy_out,
  output logic [2*WIDTH-1:0]   product  [SIZE],
  output logic                 valid_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             capture;
  logic             last_step;

  assign capture   = (state == IDLE) && valid_in;
  assign last_step = (state == RUN) && (counter == CNT_W'(WIDTH - 1));
  assign busy_out  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in) begin
            state   <= RUN;
            counter <= '0;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (last_step) begin
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Each lane pairs with divisor i/2, mirroring the divider array layout.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mult;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_q;

    assign acc_next   = mult[0] ? (acc + mcand) : acc;
    assign product[i] = prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mcand  <= '0;
        mult   <= '0;
        acc    <= '0;
        prod_q <= '0;
      end else if (capture) begin
        mcand <= {{WIDTH{1'b0}}, factor_a[i]};
        mult  <= factor_b[i/2];
        acc   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        if (last_step) begin
          prod_q <= acc_next;
        end
      end
    end
  end : g_lane

endmodule : multiplier_top
`default_nettype wire

// File: tb/tb_multiplier_top.sv
`default_nettype none
// ============================================================================
// tb_multiplier_top : scoreboard bench for multiplier_top, directed vectors
// Revision 1.0
// ============================================================================
module tb_multiplier_top;

  localparam int SIZE  = 6;
  localparam int WIDTH = 9;
  localparam int PW    = 2 * WIDTH;

  typedef logic [SIZE-1:0][PW-1:0] pset_t;

  logic            clk;
  logic            rst_n;
  logic [WIDTH-1:0] factor_a [SIZE];
  logic [WIDTH-1:0] factor_b [SIZE/2];
  logic            valid_in;
  logic            busy_out;
  logic [PW-1:0]   product  [SIZE];
  logic            valid_out;

  multiplier_top #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .factor_a (factor_a),
    .factor_b (factor_b),
    .valid_in (valid_in),
    .busy_out (busy_out),
    .product  (product),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  pset_t exp_q[$];

  int a_v [SIZE];
  int b_v [SIZE/2];
  int e_v [SIZE];

  // Monitor: pops an expected set on every valid_out and checks hold behaviour.
  logic [PW-1:0] prev_prod [SIZE];
  logic          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) prev_prod[i] = product[i];
      prev_valid = 1'b0;
    end else begin
      if (valid_out) begin
        n_vec++;
        if (prev_valid) begin
          n_err++;
          $display("FAIL pulse_width: valid_out=1 on consecutive cycles, required single-cycle pulse");
        end
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: valid_out=1 with no request outstanding");
        end else begin
          pset_t e;
          e = exp_q.pop_front();
          for (int i = 0; i < SIZE; i++) begin
            n_vec++;
            if (product[i] !== e[i]) begin
              n_err++;
              $display("FAIL product[%0d]: got %0d, expected %0d", i, product[i], e[i]);
            end
          end
        end
      end else begin
        for (int i = 0; i < SIZE; i++) begin
          n_vec++;
          if (product[i] !== prev_prod[i]) begin
            n_err++;
            $display("FAIL hold[%0d]: product changed to %0d from %0d without valid_out", i, product[i], prev_prod[i]);
          end
        end
      end
      for (int i = 0; i < SIZE; i++) prev_prod[i] = product[i];
      prev_valid = valid_out;
    end
  end

  task automatic drive_operands();
    for (int i = 0; i < SIZE; i++)   factor_a[i] = a_v[i][WIDTH-1:0];
    for (int j = 0; j < SIZE/2; j++) factor_b[j] = b_v[j][WIDTH-1:0];
  endtask

  // Presents a_v/b_v for one capture edge; returns #1 after that edge.
  task automatic request(input bit push);
    pset_t e;
    @(negedge clk);
    drive_operands();
    valid_in = 1'b1;
    if (push) begin
      for (int i = 0; i < SIZE; i++) e[i] = e_v[i][PW-1:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Called #1 after the capture edge: counts edges to valid_out and busy cycles.
  task automatic measure(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_out && lat < 0) lat = k;
      if (!busy_out) break;
      bcnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check_int({name, "_busy"}, int'(busy_out), 0);
    check_int({name, "_valid"}, int'(valid_out), 0);
    for (int i = 0; i < SIZE; i++) check_int({name, "_product"}, int'(product[i]), 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_out || exp_q.size() != 0) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy_out=%0d pending=%0d after 40 cycles, required idle", busy_out, exp_q.size());
    end
  endtask

  int lat, bcnt;

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < SIZE; i++)   factor_a[i] = '0;
    for (int j = 0; j < SIZE/2; j++) factor_b[j] = '0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vector with latency and busy-duration checks.
    a_v = '{64, 20, 41, 1, 18, 50};
    b_v = '{3, 1, 7};
    e_v = '{192, 60, 41, 1, 126, 350};
    request(1'b1);
    measure(lat, bcnt);
    check_int("latency_basic", lat, WIDTH);
    check_int("busy_cycles_basic", bcnt, WIDTH + 1);
    wait_idle();

    // Full-scale operands: largest possible product.
    a_v = '{511, 511, 511, 511, 511, 511};
    b_v = '{511, 511, 511};
    e_v = '{261121, 261121, 261121, 261121, 261121, 261121};
    request(1'b1);
    wait_idle();

    // Zero operands keep the same latency.
    a_v = '{0, 5, 0, 7, 9, 0};
    b_v = '{0, 0, 4};
    e_v = '{0, 0, 0, 0, 36, 0};
    request(1'b1);
    measure(lat, bcnt);
    check_int("latency_zero", lat, WIDTH);
    wait_idle();

    // A request while busy is ignored; the next one after busy falls completes.
    a_v = '{10, 11, 12, 13, 14, 15};
    b_v = '{2, 3, 4};
    e_v = '{20, 22, 36, 39, 56, 60};
    request(1'b1);
    repeat (2) @(posedge clk);
    a_v = '{100, 101, 102, 103, 104, 105};
    b_v = '{5, 5, 5};
    request(1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 check_int("ignored_request_busy", int'(busy_out), 0);
    a_v = '{255, 256, 300, 1, 2, 3};
    b_v = '{2, 10, 100};
    e_v = '{510, 512, 3000, 10, 200, 300};
    request(1'b1);
    wait_idle();

    // Reset during RUN aborts the request without any result.
    a_v = '{7, 7, 7, 7, 7, 7};
    b_v = '{7, 7, 7};
    request(1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 3) @(posedge clk);
    #1 check_int("abort_no_busy", int'(busy_out), 0);
    a_v = '{1, 2, 3, 4, 5, 6};
    b_v = '{400, 300, 200};
    e_v = '{400, 800, 900, 1200, 1000, 1200};
    request(1'b1);
    wait_idle();

    // Operands scrambled every cycle during RUN must not affect the result.
    a_v = '{123, 45, 67, 89, 200, 511};
    b_v = '{2, 5, 11};
    e_v = '{246, 90, 335, 445, 2200, 5621};
    request(1'b1);
    for (int k = 0; k < WIDTH + 1; k++) begin
      for (int i = 0; i < SIZE; i++)   factor_a[i] = WIDTH'(k * 37 + i * 13 + 1);
      for (int j = 0; j < SIZE/2; j++) factor_b[j] = WIDTH'(k * 59 + j * 7 + 3);
      @(posedge clk);
      #1;
    end
    wait_idle();

    repeat (3) @(posedge clk);
    #1 check_int("pending_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multiplier_top
`default_nettype wire
